// File: rtl/bcd_run_counter.sv
// bcd_run_counter
//   Front end for the four-digit seven-segment display multiplexer. Three raw
//   push-buttons are synchronised, debounced and edge-detected. The resulting
//   presses drive a run/pause/clear state machine and a prescaled BCD up/down
//   counter whose packed digits feed the display scanner.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   BTN_RUN  in   raw button, a press toggles run/pause
//   BTN_CLR  in   raw button, a press clears the count and stops
//   BTN_DIR  in   raw button, a press toggles the count direction
//   Digits   out  packed BCD value, digit k in bits [4k+3:4k]
//   Running  out  high while counting is enabled
//   Up       out  1 = count up, 0 = count down
//   Update   out  one-cycle strobe in the first cycle Digits shows a new value
module bcd_run_counter #(
  parameter int TICK_DIV  = 100000000,
  parameter int DB_CYCLES = 1000000,
  parameter int DIGITS    = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                BTN_RUN,
  input  logic                BTN_CLR,
  input  logic                BTN_DIR,
  output logic [4*DIGITS-1:0] Digits,
  output logic                Running,
  output logic                Up,
  output logic                Update
);

  localparam int NB    = 3;
  localparam int B_RUN = 0;
  localparam int B_CLR = 1;
  localparam int B_DIR = 2;
  localparam int DBW   = $clog2(DB_CYCLES);
  localparam int PW    = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] press;

  assign btn_raw = {BTN_DIR, BTN_CLR, BTN_RUN};

  // ---------------------------------------------------------------------------
  // Button path: 2-flop synchroniser -> debouncer -> rising-edge detect
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NB; gi++) begin : g_btn
    logic           sync1_q;
    logic           sync2_q;
    logic           db_q;
    logic           db_prev_q;
    logic [DBW-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= btn_raw[gi];
        sync2_q   <= sync1_q;
        db_prev_q <= db_q;
        // The counter measures how long the synchronised input has disagreed
        // with the accepted level; any agreement restarts the measurement.
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DBW'(DB_CYCLES - 1)) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    // Both terms are flops, so the press pulse is glitch-free and exactly one
    // cycle long; releases (falling db) never produce a press.
    assign press[gi] = db_q & ~db_prev_q;
  end

  // ---------------------------------------------------------------------------
  // BCD step: every digit below the stepping digit is at its limit (9 going up,
  // 0 going down), so the enable ripples upward through the digits.
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] digits_q;
  logic [4*DIGITS-1:0] digits_d;
  logic [DIGITS-1:0]   step_en;
  logic                up_q;

  assign step_en[0] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd
    logic [3:0] dig;
    logic [3:0] nxt;

    assign dig = digits_q[4*gi +: 4];

    always_comb begin
      nxt = dig;
      if (step_en[gi]) begin
        if (up_q) begin
          nxt = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        end else begin
          nxt = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
        end
      end
    end

    assign digits_d[4*gi +: 4] = nxt;

    if (gi < DIGITS - 1) begin : g_carry
      assign step_en[gi+1] = step_en[gi] & (up_q ? (dig == 4'd9) : (dig == 4'd0));
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, prescaler and count register
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic          running_q;
  logic          update_q;
  logic          tick;

  assign tick = (state_q == S_RUN) && (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      digits_q  <= '0;
      up_q      <= 1'b1;
      running_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      update_q <= 1'b0;

      // A tick in the same cycle still steps with the old direction, because
      // digits_d is built from the current up_q.
      if (press[B_DIR]) begin
        up_q <= ~up_q;
      end

      if (press[B_CLR]) begin
        // Clear wins over run presses and ticks in the same cycle.
        state_q   <= S_IDLE;
        presc_q   <= '0;
        digits_q  <= '0;
        running_q <= 1'b0;
        update_q  <= |digits_q;
      end else begin
        if (tick) begin
          digits_q <= digits_d;
          update_q <= 1'b1;
        end

        case (state_q)
          S_IDLE: begin
            if (press[B_RUN]) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
              presc_q   <= '0;
            end
          end
          S_RUN: begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (press[B_RUN]) begin
              // Pausing freezes the prescaler where it is, unless this cycle
              // also ticked, in which case it has already wrapped to zero.
              state_q   <= S_PAUSE;
              running_q <= 1'b0;
              if (!tick) begin
                presc_q <= presc_q;
              end
            end
          end
          S_PAUSE: begin
            if (press[B_RUN]) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Digits  = digits_q;
  assign Running = running_q;
  assign Up      = up_q;
  assign Update  = update_q;

endmodule
